// File: rtl/uart_pkg.sv
// Shared UART definitions for the receiver and transmitter.
// Receiver FSM encoding plus default baud divider and frame length.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } rx_state_t;

  localparam int BAUD_DIV_DEF = 2604;
  localparam int FRAME_BITS   = 10;

endpackage

// File: rtl/uart_rx_sync2.sv
// Two-flop synchroniser for one asynchronous input, preset high.
// Both stages are exported so callers can detect edges without extra flops.
module sync2 (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic q1_o,
  output logic q_o
);

  logic s1_q;
  logic s2_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q <= 1'b1;
      s2_q <= 1'b1;
    end else begin
      s1_q <= d_i;
      s2_q <= s1_q;
    end
  end

  assign q1_o = s1_q;
  assign q_o  = s2_q;

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: mid-bit sampling, one-byte holding register,
// ready and framing-error flags cleared by the consumer.
module uart_rx
  import uart_pkg::*;
#(
  parameter int BAUD_DIV = BAUD_DIV_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       RX,
  input  logic       clr_rdy,
  output logic [7:0] rx_data,
  output logic       rdy,
  output logic       frm_err
);

  localparam logic [11:0] HALF = 12'(BAUD_DIV / 2 - 1);
  localparam logic [11:0] FULL = 12'(BAUD_DIV - 1);

  logic rx_s1;
  logic rx_s;
  logic fall;
  logic sample;

  rx_state_t   state_q;
  logic [11:0] baud_cnt_q;
  logic [3:0]  bit_cnt_q;
  logic [7:0]  shift_q;
  logic [7:0]  rx_data_q;
  logic        rdy_q;
  logic        frm_err_q;

  sync2 u_sync (
    .clk  (clk),
    .rst_n(rst_n),
    .d_i  (RX),
    .q1_o (rx_s1),
    .q_o  (rx_s)
  );

  assign fall   = ~rx_s1 & rx_s;
  assign sample = (state_q != IDLE) && (baud_cnt_q == 12'd0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      baud_cnt_q <= 12'd0;
      bit_cnt_q  <= 4'd0;
      shift_q    <= 8'h00;
      rx_data_q  <= 8'h00;
      rdy_q      <= 1'b0;
      frm_err_q  <= 1'b0;
    end else begin
      if (state_q != IDLE)
        baud_cnt_q <= sample ? FULL : baud_cnt_q - 12'd1;
      // Flag sets below are written later so they override the clear.
      if (clr_rdy) begin
        rdy_q     <= 1'b0;
        frm_err_q <= 1'b0;
      end
      unique case (state_q)
        IDLE: begin
          if (fall) begin
            state_q    <= START;
            baud_cnt_q <= HALF;
            bit_cnt_q  <= 4'd0;
            rdy_q      <= 1'b0;
            frm_err_q  <= 1'b0;
          end
        end
        START: begin
          if (sample)
            state_q <= rx_s ? IDLE : DATA;
        end
        DATA: begin
          if (sample) begin
            shift_q   <= {rx_s, shift_q[7:1]};
            bit_cnt_q <= bit_cnt_q + 4'd1;
            if (bit_cnt_q == 4'd7)
              state_q <= STOP;
          end
        end
        STOP: begin
          if (sample) begin
            if (rx_s) begin
              rx_data_q <= shift_q;
              rdy_q     <= 1'b1;
              frm_err_q <= 1'b0;
            end else begin
              frm_err_q <= 1'b1;
            end
            state_q <= IDLE;
          end
        end
      endcase
    end
  end

  assign rx_data = rx_data_q;
  assign rdy     = rdy_q;
  assign frm_err = frm_err_q;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx with a short baud divider.
// Frames are driven bit by bit on the falling clock edge.
module tb_uart_rx;

  localparam int BD      = 64;
  localparam int LAT_MAX = (19 * BD) / 2 + 3;
  localparam int LAT_MIN = 9 * BD + BD / 2;

  logic       clk;
  logic       rst_n;
  logic       RX;
  logic       clr_rdy;
  logic [7:0] rx_data;
  logic       rdy;
  logic       frm_err;

  int n_assert = 0;
  int n_fail   = 0;

  uart_rx #(.BAUD_DIV(BD)) u_dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .RX     (RX),
    .clr_rdy(clr_rdy),
    .rx_data(rx_data),
    .rdy    (rdy),
    .frm_err(frm_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic drive_bit(input logic b);
    RX = b;
    repeat (BD) @(negedge clk);
  endtask

  task automatic drive_head(input logic [7:0] d);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop);
    drive_head(d);
    drive_bit(stop);
  endtask

  initial begin
    int n;
    int total;

    rst_n   = 1'b0;
    RX      = 1'b1;
    clr_rdy = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_rdy", rdy, 0);
    chk("rst_frm", frm_err, 0);
    chk("rst_data", rx_data, 8'h00);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    // 1: single byte and latency from the falling start edge
    drive_head(8'hA5);
    RX = 1'b1;
    n = 0;
    while (!rdy && n < 2 * BD) begin
      @(negedge clk);
      n++;
    end
    total = 9 * BD + n;
    chk("t1_lat_max", total <= LAT_MAX, 1);
    chk("t1_lat_min", total >= LAT_MIN, 1);
    repeat (BD - n) @(negedge clk);
    chk("t1_rdy", rdy, 1);
    chk("t1_data", rx_data, 8'hA5);
    chk("t1_frm", frm_err, 0);

    // 2: back-to-back frames without acknowledge
    send_frame(8'h00, 1'b1);
    chk("t2_rdy0", rdy, 1);
    chk("t2_data0", rx_data, 8'h00);
    send_frame(8'hFF, 1'b1);
    chk("t2_rdy1", rdy, 1);
    chk("t2_data1", rx_data, 8'hFF);
    send_frame(8'h55, 1'b1);
    chk("t2_rdy2", rdy, 1);
    chk("t2_data2", rx_data, 8'h55);
    repeat (BD) @(negedge clk);

    // 3: short low pulse is a false start
    RX = 1'b0;
    repeat (3 * BD / 8) @(negedge clk);
    RX = 1'b1;
    repeat (3 * BD) @(negedge clk);
    chk("t3_rdy", rdy, 0);
    chk("t3_data", rx_data, 8'h55);
    chk("t3_frm", frm_err, 0);

    // 4: stop bit low, then a good frame
    send_frame(8'h3C, 1'b0);
    chk("t4_frm", frm_err, 1);
    chk("t4_rdy", rdy, 0);
    chk("t4_data", rx_data, 8'h55);
    RX = 1'b1;
    repeat (2 * BD) @(negedge clk);
    chk("t4_frm_hold", frm_err, 1);
    send_frame(8'h12, 1'b1);
    chk("t4_rdy2", rdy, 1);
    chk("t4_frm2", frm_err, 0);
    chk("t4_data2", rx_data, 8'h12);
    repeat (BD) @(negedge clk);
    clr_rdy = 1'b1;
    @(negedge clk);
    clr_rdy = 1'b0;
    chk("t4_clr", rdy, 0);
    chk("t4_clr_data", rx_data, 8'h12);

    // 5: reset in the middle of a byte
    drive_bit(1'b0);
    drive_bit(1'b1);
    drive_bit(1'b1);
    drive_bit(1'b0);
    rst_n = 1'b0;
    #1;
    chk("t5_rst_rdy", rdy, 0);
    chk("t5_rst_frm", frm_err, 0);
    chk("t5_rst_data", rx_data, 8'h00);
    RX = 1'b1;
    repeat (4) @(negedge clk);
    rst_n = 1'b1;
    repeat (2 * BD) @(negedge clk);
    chk("t5_partial", rdy, 0);
    send_frame(8'h81, 1'b1);
    chk("t5_rdy", rdy, 1);
    chk("t5_data", rx_data, 8'h81);
    chk("t5_frm", frm_err, 0);
    repeat (BD) @(negedge clk);

    // 6: acknowledge coincides with the stop sample
    drive_head(8'h7E);
    RX = 1'b1;
    repeat (BD / 2 + 1) @(negedge clk);
    clr_rdy = 1'b1;
    @(negedge clk);
    clr_rdy = 1'b0;
    chk("t6_rdy", rdy, 1);
    chk("t6_data", rx_data, 8'h7E);
    repeat (BD) @(negedge clk);
    chk("t6_rdy_hold", rdy, 1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
